// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrated N-channel multiplexer.
package arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // Wraps at n rather than at a power of two, so non-power-of-two N rotate correctly.
  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_muxn_rr_pick.sv
// Rotating-base priority encoder: the first set request found from base upward, wrapping at N.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] base,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SELW'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_muxn.sv
// N-channel arbitrated multiplexer (fixed priority or round-robin) with one registered output stage.
module arb_muxn
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = ARB_MODE_RR,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // producers hold valid and data stable until they see ready.
  logic             load;
  logic             any;
  logic             xfer;
  logic [N-1:0]     force_mask;
  logic [N-1:0]     eligible;
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  pick_base;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  assign load = ~out_valid_q | out_ready;

  // An out-of-range force_sel matches no channel and so leaves the eligible set empty.
  always_comb begin
    force_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (force_sel == SELW'(i)) force_mask[i] = 1'b1;
    end
  end

  assign eligible  = force_en ? (in_valid & force_mask) : in_valid;
  assign pick_base = (MODE == ARB_MODE_RR) ? rr_ptr_q : '0;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req     (eligible),
    .base    (pick_base),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign in_ready = reset ? '0 : (gnt & {N{load}});
  assign xfer     = any & load;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      if (MODE == ARB_MODE_RR) begin
        rr_ptr_d = SELW'(mod_inc(32'(gnt_idx), 32'(N)));
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn: four instances (N=4 RR, N=4 fixed, N=3 RR, N=5 RR) share one stimulus bus.
module tb_arb_muxn;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   v;
  logic [159:0] dat;
  logic         fen;
  logic [1:0]   fs2;
  logic [2:0]   fs3;
  logic         ordy;

  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic [4:0]  ir3;
  logic        ov0, ov1, ov2, ov3;
  logic [31:0] od0, od1, od2, od3;
  logic [1:0]  os0, os1, os2;
  logic [2:0]  os3;

  logic [4:0]  ir_a[4];
  logic        ov_a[4];
  logic [31:0] od_a[4];
  logic [2:0]  os_a[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_muxn #(.WIDTH(32), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .reset(rst), .in_valid(v[3:0]), .in_data(dat[127:0]), .in_ready(ir0),
    .force_en(fen), .force_sel(fs2), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy));
  arb_muxn #(.WIDTH(32), .N(4), .MODE(0)) u_fp4 (
    .clk(clk), .reset(rst), .in_valid(v[3:0]), .in_data(dat[127:0]), .in_ready(ir1),
    .force_en(fen), .force_sel(fs2), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy));
  arb_muxn #(.WIDTH(32), .N(3), .MODE(1)) u_rr3 (
    .clk(clk), .reset(rst), .in_valid(v[2:0]), .in_data(dat[95:0]), .in_ready(ir2),
    .force_en(fen), .force_sel(fs2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy));
  arb_muxn #(.WIDTH(32), .N(5), .MODE(1)) u_rr5 (
    .clk(clk), .reset(rst), .in_valid(v), .in_data(dat), .in_ready(ir3),
    .force_en(fen), .force_sel(fs3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy));

  always_comb begin
    ir_a[0] = {1'b0, ir0};  ov_a[0] = ov0;  od_a[0] = od0;  os_a[0] = {1'b0, os0};
    ir_a[1] = {1'b0, ir1};  ov_a[1] = ov1;  od_a[1] = od1;  os_a[1] = {1'b0, os1};
    ir_a[2] = {2'b0, ir2};  ov_a[2] = ov2;  od_a[2] = od2;  os_a[2] = {1'b0, os2};
    ir_a[3] = ir3;          ov_a[3] = ov3;  od_a[3] = od3;  os_a[3] = os3;
  end

  // Reference model: channel count, policy and output-stage contents per instance.
  int          m_n[4]    = '{4, 4, 3, 5};
  int          m_mode[4] = '{1, 0, 1, 1};
  bit          m_ov[4];
  logic [31:0] m_od[4];
  int          m_os[4];
  int          m_ptr[4];

  function automatic int m_pick(int d);
    int fsel;
    int c;
    fsel = (d == 3) ? int'(fs3) : int'(fs2);
    for (int k = 0; k < m_n[d]; k++) begin
      c = (m_mode[d] == 1) ? (m_ptr[d] + k) % m_n[d] : k;
      if (v[c] && (!fen || fsel == c)) return c;
    end
    return -1;
  endfunction

  function automatic bit m_load(int d);
    return !m_ov[d] || ordy;
  endfunction

  function automatic logic [4:0] m_ir(int d);
    int g;
    g = m_pick(d);
    if (g >= 0 && m_load(d)) return 5'd1 << g;
    return 5'd0;
  endfunction

  task automatic model_clock();
    int g;
    for (int d = 0; d < 4; d++) begin
      g = m_pick(d);
      if (g >= 0 && m_load(d)) begin
        m_ov[d] = 1'b1;
        m_od[d] = dat[g*32 +: 32];
        m_os[d] = g;
        if (m_mode[d] == 1) m_ptr[d] = (g + 1) % m_n[d];
      end else if (ordy) begin
        m_ov[d] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_a();
    for (int c = 0; c < 5; c++) dat[c*32 +: 32] = 32'hA0 + 32'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0; fen = 1'b0; fs2 = '0; fs3 = '0; ordy = 1'b0;
    set_data_a();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 5'b11111; fen = 1'b0; fs2 = '0; fs3 = '0; ordy = 1'b1;
    set_data_a();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({ov_a[d], od_a[d], os_a[d], ir_a[d]} !== 41'd0) begin
        errors++;
        $display("FAIL reset dut%0d: ov=%b od=%h os=%0d ir=%b, required all zero", d, ov_a[d], od_a[d], os_a[d], ir_a[d]);
      end
    end
    model_reset();
  endtask

  task automatic test_rr_rotation();
    do_reset();
    v = 5'b11111; ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (ir0 !== (4'd1 << (k % 4))) begin
        errors++; $display("FAIL rr_ready k=%0d: ir=%b required %b", k, ir0, 4'd1 << (k % 4));
      end
      step();
      checks++;
      if ({ov0, od0, os0} !== {1'b1, 32'hA0 + 32'(k % 4), 2'(k % 4)}) begin
        errors++; $display("FAIL rr_seq k=%0d: ov=%b od=%h os=%0d required 1 %h %0d", k, ov0, od0, os0, 32'hA0 + 32'(k % 4), k % 4);
      end
      checks++;
      if ({ov1, os1} !== {1'b1, 2'd0}) begin
        errors++; $display("FAIL fp_all_valid k=%0d: ov=%b os=%0d required 1 0", k, ov1, os1);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    v = 5'b01010; ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ir1 !== 4'b0010) begin
        errors++; $display("FAIL fp_ready k=%0d: ir=%b required 0010", k, ir1);
      end
      step();
      checks++;
      if ({ov1, od1, os1} !== {1'b1, 32'hA1, 2'd1}) begin
        errors++; $display("FAIL fp_grant k=%0d: ov=%b od=%h os=%0d required 1 a1 1", k, ov1, od1, os1);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    dat[31:0] = 32'h55; v = 5'b00001; ordy = 1'b1;
    step();
    v = 5'b00100; ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({ir1, ir0} !== 8'd0) begin
        errors++; $display("FAIL stall_ready k=%0d: ir_fp=%b ir_rr=%b required 0000", k, ir1, ir0);
      end
      step();
      checks++;
      if ({ov1, od1, ov0, od0} !== {1'b1, 32'h55, 1'b1, 32'h55}) begin
        errors++; $display("FAIL stall_hold k=%0d: fp=%b/%h rr=%b/%h required 1/55", k, ov1, od1, ov0, od0);
      end
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (ir1 !== 4'b0100) begin
      errors++; $display("FAIL drain_ready: ir=%b required 0100", ir1);
    end
    step();
    checks++;
    if ({ov1, od1, os1} !== {1'b1, 32'hA2, 2'd2}) begin
      errors++; $display("FAIL drain_load: ov=%b od=%h os=%0d required 1 a2 2", ov1, od1, os1);
    end
  endtask

  task automatic test_force();
    do_reset();
    v = 5'b11111; ordy = 1'b1; fen = 1'b1; fs2 = 2'd2; fs3 = 3'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({ir0, ir3} !== {4'b0100, 5'b00100}) begin
        errors++; $display("FAIL force_ready k=%0d: ir_rr4=%b ir_rr5=%b required 0100 00100", k, ir0, ir3);
      end
      step();
      checks++;
      if ({os0, od0} !== {2'd2, 32'hA2}) begin
        errors++; $display("FAIL force_grant k=%0d: os=%0d od=%h required 2 a2", k, os0, od0);
      end
    end
    fs2 = 2'd3; fs3 = 3'd5;
    #1;
    checks++;
    if ({ir0, ir2, ir3} !== {4'b1000, 3'b000, 5'b00000}) begin
      errors++; $display("FAIL force_range: ir_rr4=%b ir_rr3=%b ir_rr5=%b required 1000 000 00000", ir0, ir2, ir3);
    end
    step();
    checks++;
    if ({ov3, os3, od3, ov2} !== {1'b0, 3'd2, 32'hA2, 1'b0}) begin
      errors++; $display("FAIL force_drain: ov5=%b os5=%0d od5=%h ov3=%b required 0 2 a2 0", ov3, os3, od3, ov2);
    end
    fen = 1'b0;
  endtask

  task automatic test_wrap_n3();
    do_reset();
    v = 5'b00100; ordy = 1'b1;
    step();
    checks++;
    if ({ov2, os2} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL wrap_first: ov=%b os=%0d required 1 2", ov2, os2);
    end
    v = 5'b11111;
    #1;
    checks++;
    if (ir2 !== 3'b001) begin
      errors++; $display("FAIL wrap_ready: ir=%b required 001", ir2);
    end
    step();
    checks++;
    if ({os2, od2} !== {2'd0, 32'hA0}) begin
      errors++; $display("FAIL wrap_grant: os=%0d od=%h required 0 a0", os2, od2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    v = 5'b11111; ordy = 1'b0;
    step();
    checks++;
    if (ov0 !== 1'b1) begin
      errors++; $display("FAIL areset_pre: ov=%b required 1", ov0);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({ov_a[d], od_a[d], os_a[d], ir_a[d]} !== 41'd0) begin
        errors++;
        $display("FAIL areset dut%0d: ov=%b od=%h os=%0d ir=%b, required all zero", d, ov_a[d], od_a[d], os_a[d], ir_a[d]);
      end
    end
    rst = 1'b0;
    model_reset();
    ordy = 1'b1;
    #1;
    checks++;
    if (ir0 !== 4'b0001) begin
      errors++; $display("FAIL areset_ptr: ir=%b required 0001", ir0);
    end
    step();
    checks++;
    if ({ov0, os0, od0} !== {1'b1, 2'd0, 32'hA0}) begin
      errors++; $display("FAIL areset_grant: ov=%b os=%0d od=%h required 1 0 a0", ov0, os0, od0);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_ir;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v    = 5'($urandom_range(0, 31));
      fen  = ($urandom_range(0, 3) == 0);
      fs2  = 2'($urandom_range(0, 3));
      fs3  = 3'($urandom_range(0, 7));
      ordy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 5; c++) dat[c*32 +: 32] = $urandom;
      #1;
      for (int d = 0; d < 4; d++) begin
        exp_ir = m_ir(d);
        checks++;
        if (ir_a[d] !== exp_ir) begin
          errors++; $display("FAIL rand_ready cyc=%0d dut%0d: ir=%b required %b", cyc, d, ir_a[d], exp_ir);
        end
      end
      step();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({ov_a[d], od_a[d], os_a[d]} !== {m_ov[d], m_od[d], 3'(m_os[d])}) begin
          errors++;
          $display("FAIL rand_out cyc=%0d dut%0d: ov=%b od=%h os=%0d required %b %h %0d",
                   cyc, d, ov_a[d], od_a[d], os_a[d], m_ov[d], m_od[d], m_os[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_back_pressure();
    test_force();
    test_wrap_n3();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
